// File: rtl/controlador_busca_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, reset address, state encoding.
package controlador_busca_pkg;

  localparam int unsigned LARG_END    = 8;
  localparam int unsigned LARG_INSTR  = 8;
  localparam int unsigned LARG_CONT   = 16;
  localparam logic [LARG_END-1:0] END_INICIAL = 8'h00;

  typedef enum logic {
    Ativo  = 1'b0,
    Parado = 1'b1
  } estado_t;

endpackage

// File: rtl/controlador_busca_if.sv
// Fetch bus: instruction-memory address/data, decoder handshake and control pulses.
interface controlador_busca_if
  import controlador_busca_pkg::*;
#(
  parameter int unsigned LARGURA_ENDERECO  = LARG_END,
  parameter int unsigned LARGURA_INSTRUCAO = LARG_INSTR,
  parameter int unsigned LARGURA_CONTADOR  = LARG_CONT
) ();

  logic [LARGURA_ENDERECO-1:0]  endereco;
  logic [LARGURA_INSTRUCAO-1:0] instrucao;
  logic [LARGURA_INSTRUCAO-1:0] instrucao_saida;
  logic [LARGURA_ENDERECO-1:0]  pc_instrucao;
  logic                         valido;
  logic                         pronto;
  logic                         desvio;
  logic [LARGURA_ENDERECO-1:0]  alvo_desvio;
  logic                         parar;
  logic                         retomar;
  logic [LARGURA_CONTADOR-1:0]  contador_busca;

  modport master (
    output endereco, instrucao_saida, pc_instrucao, valido, contador_busca,
    input  instrucao, pronto, desvio, alvo_desvio, parar, retomar
  );

  modport slave (
    input  endereco, instrucao_saida, pc_instrucao, valido, contador_busca,
    output instrucao, pronto, desvio, alvo_desvio, parar, retomar
  );

endinterface

// File: rtl/controlador_busca_contador_programa.sv
// Program counter register: reset/load have priority over increment; otherwise holds.
module contador_programa
  import controlador_busca_pkg::*;
#(
  parameter int unsigned LARGURA_ENDERECO = LARG_END,
  parameter logic [LARGURA_ENDERECO-1:0] ENDERECO_INICIAL = END_INICIAL
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        carregar,
  input  logic                        incrementar,
  input  logic [LARGURA_ENDERECO-1:0] alvo,
  output logic [LARGURA_ENDERECO-1:0] pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= ENDERECO_INICIAL;
    end else if (carregar) begin
      pc <= alvo;
    end else if (incrementar) begin
      pc <= pc + LARGURA_ENDERECO'(1);
    end
  end

endmodule

// File: rtl/controlador_busca.sv
// Instruction-fetch sequencer: captures memory data one edge after the address is registered
// and offers it to the decoder on a valid/ready handshake, with redirect, halt and resume.
module controlador_busca
  import controlador_busca_pkg::*;
#(
  parameter int unsigned LARGURA_ENDERECO  = LARG_END,
  parameter int unsigned LARGURA_INSTRUCAO = LARG_INSTR,
  parameter logic [LARGURA_ENDERECO-1:0] ENDERECO_INICIAL = END_INICIAL,
  parameter int unsigned LARGURA_CONTADOR  = LARG_CONT
) (
  input logic                 clock,
  input logic                 reset,
  controlador_busca_if.master bus
);

  estado_t                      estado_q, estado_d;
  logic [LARGURA_INSTRUCAO-1:0] instr_q, instr_d;
  logic [LARGURA_ENDERECO-1:0]  pc_instr_q, pc_instr_d;
  logic                         valido_q, valido_d;
  logic [LARGURA_CONTADOR-1:0]  contador_q, contador_d;
  logic [LARGURA_ENDERECO-1:0]  pc;
  logic                         carregar, incrementar, aceite;

  contador_programa #(
    .LARGURA_ENDERECO (LARGURA_ENDERECO),
    .ENDERECO_INICIAL (ENDERECO_INICIAL)
  ) u_pc (
    .clock       (clock),
    .reset       (reset),
    .carregar    (carregar),
    .incrementar (incrementar),
    .alvo        (bus.alvo_desvio),
    .pc          (pc)
  );

  assign aceite = valido_q && bus.pronto;

  always_comb begin
    estado_d    = estado_q;
    instr_d     = instr_q;
    pc_instr_d  = pc_instr_q;
    valido_d    = valido_q;
    carregar    = 1'b0;
    incrementar = 1'b0;
    // A handshake on the same edge as a redirect or halt still retires.
    contador_d  = contador_q + LARGURA_CONTADOR'(aceite);

    if (bus.desvio) begin
      carregar = 1'b1;
      valido_d = 1'b0;
      estado_d = Ativo;
    end else if (estado_q == Ativo) begin
      if (bus.parar) begin
        estado_d = Parado;
        valido_d = 1'b0;
      end else if (!valido_q || bus.pronto) begin
        instr_d     = bus.instrucao;
        pc_instr_d  = pc;
        valido_d    = 1'b1;
        incrementar = 1'b1;
      end
    end else if (bus.retomar && !bus.parar) begin
      estado_d = Ativo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= Ativo;
      instr_q    <= '0;
      pc_instr_q <= '0;
      valido_q   <= 1'b0;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      instr_q    <= instr_d;
      pc_instr_q <= pc_instr_d;
      valido_q   <= valido_d;
      contador_q <= contador_d;
    end
  end

  assign bus.endereco        = pc;
  assign bus.instrucao_saida = instr_q;
  assign bus.pc_instrucao    = pc_instr_q;
  assign bus.valido          = valido_q;
  assign bus.contador_busca  = contador_q;

endmodule

// File: tb/tb_controlador_busca.sv
// Bench for controlador_busca: directed vector table followed by random traffic
// checked against a fetch-sequence model.
module tb_controlador_busca;

  logic clock;
  logic reset;
  logic [7:0] mem [256];

  controlador_busca_if bus ();

  controlador_busca dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory answers on the falling edge for the address currently presented.
  always @(negedge clock) bus.instrucao = mem[bus.endereco];

  int checks = 0;
  int errors = 0;

  // Model: next unfetched address, held instruction, halt flag, retired count.
  int m_end, m_instr, m_pc, m_cnt;
  bit m_val, m_parado;

  typedef struct {
    bit rst, pr, dv;
    int alvo;
    bit pa, re;
    bit val;
    int instr, pc, ende, cnt;
  } vetor_t;

  vetor_t tab[$];

  function automatic vetor_t v(bit rst, bit pr, bit dv, int alvo, bit pa, bit re,
                               bit val, int instr, int pc, int ende, int cnt);
    vetor_t r;
    r.rst = rst; r.pr = pr; r.dv = dv; r.alvo = alvo; r.pa = pa; r.re = re;
    r.val = val; r.instr = instr; r.pc = pc; r.ende = ende; r.cnt = cnt;
    return r;
  endfunction

  task automatic modelo(bit rst, bit pr, bit dv, int alvo, bit pa, bit re);
    if (rst) begin
      m_end = 0; m_instr = 0; m_pc = 0; m_val = 0; m_cnt = 0; m_parado = 0;
    end else begin
      if (m_val && pr) m_cnt = (m_cnt + 1) % 65536;
      if (dv) begin
        m_end = alvo; m_val = 0; m_parado = 0;
      end else if (!m_parado && pa) begin
        m_parado = 1; m_val = 0;
      end else if (m_parado) begin
        if (re && !pa) m_parado = 0;
      end else if (!m_val || pr) begin
        m_instr = mem[m_end]; m_pc = m_end; m_val = 1;
        m_end = (m_end + 1) % 256;
      end
    end
  endtask

  task automatic ciclo(bit rst, bit pr, bit dv, int alvo, bit pa, bit re);
    reset           = rst;
    bus.pronto      = pr;
    bus.desvio      = dv;
    bus.alvo_desvio = alvo[7:0];
    bus.parar       = pa;
    bus.retomar     = re;
    @(posedge clock);
    modelo(rst, pr, dv, alvo, pa, re);
    #1;
  endtask

  task automatic verifica(string nome, int atual, int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic compara(string tag, bit val, int instr, int pc, int ende, int cnt);
    verifica({tag, " valido"}, int'(bus.valido), int'(val));
    verifica({tag, " endereco"}, int'(bus.endereco), ende);
    verifica({tag, " contador"}, int'(bus.contador_busca), cnt);
    // Held instruction and its PC are only meaningful while valid, except right after reset.
    if (val || ende == 0 && cnt == 0 && !val && instr == 0) begin
      verifica({tag, " instrucao"}, int'(bus.instrucao_saida), instr);
      verifica({tag, " pc_instrucao"}, int'(bus.pc_instrucao), pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
    reset = 1'b1; bus.pronto = 0; bus.desvio = 0; bus.alvo_desvio = 0;
    bus.parar = 0; bus.retomar = 0;

    // rst pr dv alvo pa re | val instr pc end cnt
    tab.push_back(v(1, 0, 0, 'h00, 0, 0, 0, 'h00, 'h00, 'h00, 0));
    tab.push_back(v(1, 0, 0, 'h00, 0, 0, 0, 'h00, 'h00, 'h00, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFF, 'h00, 'h01, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFE, 'h01, 'h02, 1));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFD, 'h02, 'h03, 2));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFC, 'h03, 'h04, 3));
    tab.push_back(v(1, 0, 0, 'h00, 0, 0, 0, 'h00, 'h00, 'h00, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFF, 'h00, 'h01, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFE, 'h01, 'h02, 1));
    for (int i = 0; i < 4; i++) tab.push_back(v(0, 0, 0, 'h00, 0, 0, 1, 'hFE, 'h01, 'h02, 1));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFD, 'h02, 'h03, 2));
    tab.push_back(v(0, 0, 1, 'h80, 0, 0, 0, 'hFD, 'h02, 'h80, 2));
    tab.push_back(v(0, 0, 0, 'h00, 0, 0, 1, 'h7F, 'h80, 'h81, 2));
    tab.push_back(v(0, 1, 1, 'hFE, 0, 0, 0, 'h7F, 'h80, 'hFE, 3));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'h01, 'hFE, 'hFF, 3));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'h00, 'hFF, 'h00, 4));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFF, 'h00, 'h01, 5));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFE, 'h01, 'h02, 6));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFD, 'h02, 'h03, 7));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFC, 'h03, 'h04, 8));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFB, 'h04, 'h05, 9));
    tab.push_back(v(0, 1, 0, 'h00, 1, 0, 0, 'hFB, 'h04, 'h05, 10));
    for (int i = 0; i < 5; i++) tab.push_back(v(0, 1, 0, 'h00, 0, 0, 0, 'hFB, 'h04, 'h05, 10));
    tab.push_back(v(0, 1, 0, 'h00, 0, 1, 0, 'hFB, 'h04, 'h05, 10));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFA, 'h05, 'h06, 10));
    tab.push_back(v(0, 0, 0, 'h00, 1, 0, 0, 'hFA, 'h05, 'h06, 10));
    tab.push_back(v(0, 0, 0, 'h00, 1, 1, 0, 'hFA, 'h05, 'h06, 10));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 0, 'hFA, 'h05, 'h06, 10));
    tab.push_back(v(0, 1, 0, 'h00, 0, 1, 0, 'hFA, 'h05, 'h06, 10));
    tab.push_back(v(0, 0, 0, 'h00, 0, 0, 1, 'hF9, 'h06, 'h07, 10));
    tab.push_back(v(0, 0, 0, 'h00, 0, 0, 1, 'hF9, 'h06, 'h07, 10));
    tab.push_back(v(1, 0, 1, 'h33, 0, 0, 0, 'h00, 'h00, 'h00, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFF, 'h00, 'h01, 0));
    tab.push_back(v(0, 1, 0, 'h00, 1, 0, 0, 'hFF, 'h00, 'h01, 1));
    tab.push_back(v(1, 0, 0, 'h00, 0, 1, 0, 'h00, 'h00, 'h00, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 0, 1, 'hFF, 'h00, 'h01, 0));
    tab.push_back(v(0, 1, 0, 'h00, 0, 1, 1, 'hFE, 'h01, 'h02, 1));

    foreach (tab[i]) begin
      ciclo(tab[i].rst, tab[i].pr, tab[i].dv, tab[i].alvo, tab[i].pa, tab[i].re);
      compara($sformatf("vec%0d", i), tab[i].val, tab[i].instr, tab[i].pc, tab[i].ende,
              tab[i].cnt);
    end

    // Random traffic against the model, which has tracked the table above as well.
    for (int n = 0; n < 3000; n++) begin
      bit rst, pr, dv, pa, re;
      rst = ($urandom_range(0, 199) == 0);
      pr  = ($urandom_range(0, 3) != 0);
      dv  = ($urandom_range(0, 19) == 0);
      pa  = ($urandom_range(0, 24) == 0);
      re  = ($urandom_range(0, 9) == 0);
      ciclo(rst, pr, dv, int'($urandom_range(0, 255)), pa, re);
      verifica($sformatf("rnd%0d valido", n), int'(bus.valido), int'(m_val));
      verifica($sformatf("rnd%0d endereco", n), int'(bus.endereco), m_end);
      verifica($sformatf("rnd%0d contador", n), int'(bus.contador_busca), m_cnt);
      if (m_val) begin
        verifica($sformatf("rnd%0d instrucao", n), int'(bus.instrucao_saida), m_instr);
        verifica($sformatf("rnd%0d pc_instrucao", n), int'(bus.pc_instrucao), m_pc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
